// File: rtl/lcfg_cfg_pkg.sv
// Shared definitions for the config-bus routing stages: one-hot state encoding,
// error codes and the default error read-data pattern.
package lcfg_cfg_pkg;

  localparam int unsigned S_IDLE = 0;
  localparam int unsigned S_REQ  = 1;
  localparam int unsigned S_RESP = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_RESP = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_DECODE  = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_code_e;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_C0DE;

endpackage

// File: rtl/lcfg_cfg_timeout.sv
// Saturating up-counter with clear/enable; expired_o flags the LIMIT-th enabled cycle
// (count == LIMIT-1) and stays set while the count is held there.
module lcfg_cfg_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over enable; saturate at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/lcfg_cfgi_router.sv
// Routes one upstream irdy/trdy config transaction at a time to a target port selected by
// the upper address bits; every transaction completes, with decode/timeout error capture.
module lcfg_cfgi_router
  import lcfg_cfg_pkg::*;
#(
  parameter int unsigned NUM_TGT   = 4,
  parameter int unsigned TGT_SHIFT = 12,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfgi_irdy,
  output logic                    cfgi_trdy,
  input  logic [15:0]             cfgi_addr,
  input  logic                    cfgi_write,
  input  logic [31:0]             cfgi_wr_data,
  output logic [31:0]             cfgi_rd_data,
  output logic [NUM_TGT-1:0]      tgt_irdy,
  input  logic [NUM_TGT-1:0]      tgt_trdy,
  output logic [TGT_SHIFT-1:0]    tgt_addr,
  output logic                    tgt_write,
  output logic [31:0]             tgt_wr_data,
  input  logic [32*NUM_TGT-1:0]   tgt_rd_data,
  output logic                    err_valid,
  output logic [1:0]              err_code,
  output logic [15:0]             err_addr,
  input  logic                    err_clr
);

  localparam int unsigned SEL_W = 16 - TGT_SHIFT;

  state_e               state_q, state_d;
  logic                 cfgi_trdy_q;
  logic [31:0]          rd_data_q, rd_data_d;
  logic [NUM_TGT-1:0]   tgt_irdy_q, tgt_irdy_d;
  logic [15:0]          cap_addr_q;
  logic                 cap_write_q;
  logic [31:0]          cap_wr_data_q;
  logic                 err_valid_q;
  logic [1:0]           err_code_q;
  logic [15:0]          err_addr_q;

  logic [SEL_W-1:0]     sel_s;
  logic                 hit_s;
  logic [NUM_TGT-1:0]   sel_oh_s;
  logic                 accept_s;
  logic                 trdy_hit_s;
  logic                 expired_s;
  logic [31:0]          tgt_rd_s;
  logic                 err_new_s;
  logic [1:0]           err_new_code_s;
  logic [15:0]          err_new_addr_s;

  // The trdy guard keeps IDLE from re-accepting an irdy that is still high on the completion cycle.
  assign accept_s = state_q[S_IDLE] & cfgi_irdy & ~cfgi_trdy_q;

  // Address decode and selected-target response muxing (tgt_irdy_q is the one-hot select).
  always_comb begin
    sel_s      = cfgi_addr[15:TGT_SHIFT];
    hit_s      = (32'(sel_s) < NUM_TGT);
    trdy_hit_s = |(tgt_trdy & tgt_irdy_q);
    tgt_rd_s   = 32'h0;
    for (int i = 0; i < NUM_TGT; i++) begin
      sel_oh_s[i] = (32'(sel_s) == 32'(i));
      tgt_rd_s    = tgt_rd_s | ({32{tgt_irdy_q[i]}} & tgt_rd_data[32*i +: 32]);
    end
  end

  // Next-state, target request, read data and error detection.
  always_comb begin
    state_d        = state_q;
    tgt_irdy_d     = '0;
    rd_data_d      = rd_data_q;
    err_new_s      = 1'b0;
    err_new_code_s = ERR_NONE;
    err_new_addr_s = cap_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && hit_s) begin
          state_d    = ST_REQ;
          tgt_irdy_d = sel_oh_s;
        end else if (accept_s) begin
          state_d        = ST_RESP;
          rd_data_d      = ERR_DATA;
          err_new_s      = 1'b1;
          err_new_code_s = ERR_DECODE;
          err_new_addr_s = cfgi_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (trdy_hit_s) begin
          state_d   = ST_RESP;
          rd_data_d = cap_write_q ? rd_data_q : tgt_rd_s;
        end else if (expired_s) begin
          state_d        = ST_RESP;
          rd_data_d      = ERR_DATA;
          err_new_s      = 1'b1;
          err_new_code_s = ERR_TIMEOUT;
        end else begin
          tgt_irdy_d = tgt_irdy_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  lcfg_cfg_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk),
    .reset_i   (reset),
    .clr_i     (state_q[S_IDLE]),
    .en_i      (state_q[S_REQ]),
    .expired_o (expired_s)
  );

  // Transaction state, capture and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cfgi_trdy_q   <= 1'b0;
      rd_data_q     <= 32'h0;
      tgt_irdy_q    <= '0;
      cap_addr_q    <= 16'h0;
      cap_write_q   <= 1'b0;
      cap_wr_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cfgi_trdy_q <= state_q[S_RESP];
      rd_data_q   <= rd_data_d;
      tgt_irdy_q  <= tgt_irdy_d;
      if (accept_s) begin
        cap_addr_q    <= cfgi_addr;
        cap_write_q   <= cfgi_write;
        cap_wr_data_q <= cfgi_wr_data;
      end
    end
  end

  // First-error capture; a new error in the clear cycle is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_addr_q  <= 16'h0;
    end else if (err_new_s && (!err_valid_q || err_clr)) begin
      err_valid_q <= 1'b1;
      err_code_q  <= err_new_code_s;
      err_addr_q  <= err_new_addr_s;
    end else if (err_clr) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_addr_q  <= 16'h0;
    end
  end

  assign cfgi_trdy    = cfgi_trdy_q;
  assign cfgi_rd_data = rd_data_q;
  assign tgt_irdy     = tgt_irdy_q;
  assign tgt_addr     = cap_addr_q[TGT_SHIFT-1:0];
  assign tgt_write    = cap_write_q;
  assign tgt_wr_data  = cap_wr_data_q;
  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_addr     = err_addr_q;

endmodule

// File: tb/tb_lcfg_cfgi_router.sv
// Directed bench for lcfg_cfgi_router (4 targets, TIMEOUT=8) with hand-computed expectations.
module tb_lcfg_cfgi_router;

  logic         clk = 1'b0;
  logic         reset, cfgi_irdy, cfgi_write, err_clr;
  logic         cfgi_trdy, tgt_write, err_valid;
  logic [15:0]  cfgi_addr, err_addr;
  logic [31:0]  cfgi_wr_data, cfgi_rd_data, tgt_wr_data;
  logic [3:0]   tgt_irdy, tgt_trdy;
  logic [11:0]  tgt_addr;
  logic [127:0] tgt_rd_data;
  logic [1:0]   err_code;

  int           total = 0;
  int           bad = 0;
  int           lat;
  logic [31:0]  rd_got;
  logic [3:0]   irdy_seen;
  logic [11:0]  addr_seen;
  logic         wr_seen;
  logic [31:0]  wd_seen;
  int           pulses;

  always #5 clk = ~clk;

  lcfg_cfgi_router #(
    .NUM_TGT   (4),
    .TGT_SHIFT (12),
    .TIMEOUT   (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfgi_irdy    (cfgi_irdy),
    .cfgi_trdy    (cfgi_trdy),
    .cfgi_addr    (cfgi_addr),
    .cfgi_write   (cfgi_write),
    .cfgi_wr_data (cfgi_wr_data),
    .cfgi_rd_data (cfgi_rd_data),
    .tgt_irdy     (tgt_irdy),
    .tgt_trdy     (tgt_trdy),
    .tgt_addr     (tgt_addr),
    .tgt_write    (tgt_write),
    .tgt_wr_data  (tgt_wr_data),
    .tgt_rd_data  (tgt_rd_data),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .err_addr     (err_addr),
    .err_clr      (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One upstream transaction; trdy_vec is pulsed on REQ cycle resp_after+1 (resp_after<0: never).
  task automatic do_txn(input logic [15:0] addr, input logic wr, input logic [31:0] wd,
                        input int resp_after, input logic [3:0] trdy_vec, input logic clr);
    bit done = 1'b0;
    cfgi_irdy    = 1'b1;
    cfgi_addr    = addr;
    cfgi_write   = wr;
    cfgi_wr_data = wd;
    err_clr      = clr;
    lat          = 0;
    irdy_seen    = 4'b0;
    rd_got       = 32'h0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      err_clr   = 1'b0;
      irdy_seen = irdy_seen | tgt_irdy;
      if (lat == 1) begin
        addr_seen = tgt_addr;
        wr_seen   = tgt_write;
        wd_seen   = tgt_wr_data;
      end
      tgt_trdy = (resp_after >= 0 && lat == resp_after + 1) ? trdy_vec : 4'b0;
      if (cfgi_trdy) begin
        done   = 1'b1;
        rd_got = cfgi_rd_data;
      end
    end
    if (!done) check("trdy_wait", 32'd0, 32'd1);
    cfgi_irdy = 1'b0;
    tgt_trdy  = 4'b0;
    tick();
    check("trdy_single", 32'(cfgi_trdy), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    cfgi_irdy    = 1'b0;
    cfgi_addr    = 16'h0;
    cfgi_write   = 1'b0;
    cfgi_wr_data = 32'h0;
    err_clr      = 1'b0;
    tgt_trdy     = 4'b0;
    tgt_rd_data  = {32'hCAFE_F00D, 32'h1234_5678, 32'h0BAD_BEEF, 32'h1111_2222};
    tick();
    tick();
    reset = 1'b0;
    check("rst_trdy",   32'(cfgi_trdy),  32'd0);
    check("rst_irdy",   32'(tgt_irdy),   32'd0);
    check("rst_rdata",  cfgi_rd_data,    32'd0);
    check("rst_taddr",  32'(tgt_addr),   32'd0);
    check("rst_twdata", tgt_wr_data,     32'd0);
    check("rst_errv",   32'(err_valid),  32'd0);
    check("rst_errc",   32'(err_code),   32'd0);
    check("rst_erra",   32'(err_addr),   32'd0);

    // Read target 2, trdy on the 4th REQ cycle.
    do_txn(16'h2034, 1'b0, 32'h0, 3, 4'b0100, 1'b0);
    check("rd2_irdy", 32'(irdy_seen), 32'h4);
    check("rd2_addr", 32'(addr_seen), 32'h034);
    check("rd2_wr",   32'(wr_seen),   32'd0);
    check("rd2_lat",  32'(lat),       32'd6);
    check("rd2_data", rd_got,         32'h1234_5678);
    check("rd2_errv", 32'(err_valid), 32'd0);

    // Write target 0 with same-cycle trdy; read data must stay unchanged.
    do_txn(16'h0010, 1'b1, 32'hA5A5_0F0F, 0, 4'b0001, 1'b0);
    check("wr0_irdy", 32'(irdy_seen), 32'h1);
    check("wr0_wr",   32'(wr_seen),   32'd1);
    check("wr0_wd",   wd_seen,        32'hA5A5_0F0F);
    check("wr0_lat",  32'(lat),       32'd3);
    check("wr0_data", rd_got,         32'h1234_5678);

    // Decode miss.
    do_txn(16'h7000, 1'b0, 32'h0, -1, 4'b0000, 1'b0);
    check("dec_irdy", 32'(irdy_seen), 32'h0);
    check("dec_lat",  32'(lat),       32'd2);
    check("dec_data", rd_got,         32'hDEAD_C0DE);
    check("dec_errv", 32'(err_valid), 32'd1);
    check("dec_errc", 32'(err_code),  32'h1);
    check("dec_erra", 32'(err_addr),  32'h7000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_errv", 32'(err_valid), 32'd0);
    check("clr_errc", 32'(err_code),  32'd0);
    check("clr_erra", 32'(err_addr),  32'd0);

    // Timeout on target 1, then a second timeout must not overwrite.
    do_txn(16'h1044, 1'b0, 32'h0, -1, 4'b0000, 1'b0);
    check("to1_irdy", 32'(irdy_seen), 32'h2);
    check("to1_lat",  32'(lat),       32'd10);
    check("to1_data", rd_got,         32'hDEAD_C0DE);
    check("to1_errc", 32'(err_code),  32'h2);
    check("to1_erra", 32'(err_addr),  32'h1044);
    do_txn(16'h1F00, 1'b1, 32'h5555_AAAA, -1, 4'b0000, 1'b0);
    check("to2_lat",  32'(lat),       32'd10);
    check("to2_erra", 32'(err_addr),  32'h1044);
    check("to2_errc", 32'(err_code),  32'h2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr2_errv", 32'(err_valid), 32'd0);

    // Target trdy in the final REQ cycle wins over the timeout.
    do_txn(16'h3008, 1'b0, 32'h0, 7, 4'b1000, 1'b0);
    check("edge_lat",  32'(lat),       32'd10);
    check("edge_data", rd_got,         32'hCAFE_F00D);
    check("edge_errv", 32'(err_valid), 32'd0);

    // First error held, then err_clr together with a new decode error records the new one.
    do_txn(16'h4000, 1'b0, 32'h0, -1, 4'b0000, 1'b0);
    do_txn(16'hF00F, 1'b0, 32'h0, -1, 4'b0000, 1'b0);
    check("hold_erra", 32'(err_addr), 32'h4000);
    do_txn(16'h5123, 1'b0, 32'h0, -1, 4'b0000, 1'b1);
    check("clrnew_errv", 32'(err_valid), 32'd1);
    check("clrnew_erra", 32'(err_addr),  32'h5123);
    check("clrnew_errc", 32'(err_code),  32'h1);

    // Reset during REQ aborts silently.
    cfgi_irdy = 1'b1;
    cfgi_addr = 16'h2100;
    cfgi_write = 1'b0;
    tick();
    tick();
    check("rreq_irdy", 32'(tgt_irdy), 32'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cfgi_irdy = 1'b0;
    check("rreq_irdy0", 32'(tgt_irdy),  32'd0);
    check("rreq_errv",  32'(err_valid), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (cfgi_trdy) pulses++;
      tick();
    end
    check("rreq_notrdy", 32'(pulses), 32'd0);
    do_txn(16'h1008, 1'b0, 32'h0, 1, 4'b0010, 1'b0);
    check("rec_lat",  32'(lat),   32'd4);
    check("rec_data", rd_got,     32'h0BAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcfg_cfgi_router.md
Name: lcfg_cfgi_router

Overview:
- Downstream stage of the TV80 outgoing config driver.
- Consumes its single irdy/trdy config-bus master port and routes each transaction to one of NUM_TGT target ports, decoded from the upper address bits.
- Returns target read data upstream; every transaction completes, with a timeout and an error-capture register for decode misses and hung targets.

Parameters:
- NUM_TGT, 4, number of downstream target ports (1..16).
- TGT_SHIFT, 12, LSB of the target-select field; select = cfgi_addr[15:TGT_SHIFT].
- TIMEOUT, 255, max cycles in REQ before forced completion (>=2).
- ERR_DATA, 32'hDEAD_C0DE, read data returned on decode or timeout error.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- cfgi_irdy, input, 1, upstream request valid; held until cfgi_trdy.
- cfgi_trdy, output, 1, upstream completion pulse; registered.
- cfgi_addr, input, 16, transaction address.
- cfgi_write, input, 1, 1=write, 0=read.
- cfgi_wr_data, input, 32, write data.
- cfgi_rd_data, output, 32, read data; valid when cfgi_trdy=1.
- tgt_irdy, output, NUM_TGT, one-hot request to the selected target; registered.
- tgt_trdy, input, NUM_TGT, per-target completion pulse.
- tgt_addr, output, TGT_SHIFT, captured cfgi_addr[TGT_SHIFT-1:0].
- tgt_write, output, 1, captured cfgi_write.
- tgt_wr_data, output, 32, captured write data.
- tgt_rd_data, input, 32*NUM_TGT, target read data; target i occupies [32i+31:32i].
- err_valid, output, 1, sticky error flag.
- err_code, output, 2, 01=decode miss, 10=timeout.
- err_addr, output, 16, address of the first unclered error.
- err_clr, input, 1, clears err_valid, err_code and err_addr.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all counters and outputs cleared.
  - cfgi_trdy=0, tgt_irdy=0, cfgi_rd_data=0, tgt_addr/tgt_write/tgt_wr_data=0.
  - err_valid=0, err_code=0, err_addr=0.
  - Reset mid-transaction aborts silently: no trdy pulse in either direction.
- State machine is one-hot: IDLE, REQ, RESP.
- IDLE:
  - When cfgi_irdy=1, capture addr, write and wr_data; compute sel=cfgi_addr[15:TGT_SHIFT].
  - If sel<NUM_TGT: go to REQ, tgt_irdy[sel]=1 from the next cycle, timeout count=0.
  - If sel>=NUM_TGT: go to RESP with rd_data=ERR_DATA and raise a decode error (code 01). No target sees the request.
- REQ:
  - tgt_irdy[sel] held high; count increments each cycle.
  - tgt_trdy[sel]=1: latch tgt_rd_data slice sel into cfgi_rd_data (reads only; on writes cfgi_rd_data is unchanged), go to RESP.
  - Otherwise, if count==TIMEOUT-1: go to RESP with ERR_DATA and raise a timeout error (code 10).
  - trdy and timeout in the same cycle: trdy wins, no error.
  - tgt_trdy on non-selected bits is ignored.
- RESP: cfgi_trdy=1 for exactly one cycle, tgt_irdy=0, then IDLE.
- Minimum latency, irdy sampled to cfgi_trdy: 3 cycles with a same-cycle target trdy; 2 cycles on a decode miss.
- The upstream master drops irdy the cycle after trdy, so IDLE never re-accepts a finished transaction.
- Writes that error are dropped but still complete upstream.
- Error capture:
  - On an error with err_valid=0: set err_valid, err_code and err_addr.
  - Later errors while err_valid=1 are not recorded (first error held).
  - err_clr and a new error in the same cycle: the new error is recorded.
- Captured tgt_* fields are stable from REQ entry until the next IDLE acceptance.

Decomposition:
- Shared package lcfg_cfg_pkg holds:
  - state bit indices (S_IDLE=0, S_REQ=1, S_RESP=2);
  - error code constants ERR_NONE, ERR_DECODE, ERR_TIMEOUT;
  - the default ERR_DATA value.
- One natural sub-module: lcfg_cfg_timeout, a saturating up-counter with clear/enable and an expiry flag, reused by future bus stages.

Test Plan:
- Read, target 2: addr=16'h2034, tgt_rd_data slice2=32'h1234_5678, trdy after 4 cycles -> tgt_irdy=4'b0100, tgt_addr=12'h034, cfgi_trdy one cycle with rd_data=32'h1234_5678, err_valid=0.
- Write, target 0: addr=16'h0010, wr_data=32'hA5A5_0F0F -> tgt_write=1, tgt_wr_data=32'hA5A5_0F0F, single cfgi_trdy pulse after the target trdy.
- Decode miss: addr=16'h7000 with NUM_TGT=4 -> no tgt_irdy, cfgi_trdy 2 cycles after irdy, rd_data=32'hDEAD_C0DE, err_code=01, err_addr=16'h7000.
- Timeout: target 1 never responds, TIMEOUT=8 -> cfgi_trdy after the 8th REQ cycle, rd_data=ERR_DATA, err_code=10. A second timeout leaves err_addr unchanged; err_clr pulse -> err_valid=0.
- Boundary: tgt_trdy in the final REQ cycle (count=TIMEOUT-1) -> normal data, no error. err_clr coinciding with a decode error -> err_valid stays 1 with the new address.
- Reset asserted during REQ -> next cycle tgt_irdy=0, cfgi_trdy never pulses; the next transaction completes normally.
